// File: rtl/cordic_result_fifo.sv
// Result buffer between a free-running CORDIC and the Jacobi controller.
// Captures (x, y, z) words, presents them FWFT, warns early via afull_o.
module cordic_result_fifo #(
    parameter  int DATA_WIDTH   = 16,
    parameter  int CHANNELS     = 3,
    parameter  int DEPTH        = 32,
    parameter  int AFULL_MARGIN = 16,
    localparam int LEVEL_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_dat_i,
    input  logic                           in_vld_i,
    output logic                           in_rdy_o,
    output logic                           afull_o,
    output logic [CHANNELS*DATA_WIDTH-1:0] out_dat_o,
    output logic                           out_vld_o,
    input  logic                           out_rdy_i,
    output logic [LEVEL_WIDTH-1:0]         level_o,
    output logic                           overflow_o,
    input  logic                           flush_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int WW = CHANNELS * DATA_WIDTH;
    localparam logic [LEVEL_WIDTH-1:0] FULL_LVL  = LEVEL_WIDTH'(DEPTH);
    localparam logic [LEVEL_WIDTH-1:0] AFULL_LVL = LEVEL_WIDTH'(DEPTH - AFULL_MARGIN);
    localparam logic [LEVEL_WIDTH-1:0] LVL_ONE   = LEVEL_WIDTH'(1);
    localparam logic [PW-1:0]          PTR_ONE   = PW'(1);

    logic [WW-1:0]          mem_q [DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LEVEL_WIDTH-1:0] level_q, level_d;
    logic                   vld_q;
    logic                   rdy_q;
    logic                   afull_q;
    logic                   ovf_q, ovf_d;
    logic                   wr_en, rd_en, drop;

    always_comb begin
        wr_en    = in_vld_i && rdy_q && !flush_i;
        rd_en    = vld_q && out_rdy_i && !flush_i;
        drop     = in_vld_i && !rdy_q && !flush_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q || drop;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
            // Simultaneous read and write leaves the level unchanged
            unique case ({wr_en, rd_en})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            vld_q    <= 1'b0;
            rdy_q    <= 1'b0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            vld_q    <= (level_d != '0);
            rdy_q    <= (level_d != FULL_LVL);
            afull_q  <= (level_d >= AFULL_LVL);
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= in_dat_i;
    end

    assign out_dat_o  = vld_q ? mem_q[rd_ptr_q] : '0;
    assign out_vld_o  = vld_q;
    assign in_rdy_o   = rdy_q;
    assign afull_o    = afull_q;
    assign level_o    = level_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_cordic_result_fifo.sv
// Directed bench for cordic_result_fifo with a queue scoreboard
// and a small occupancy model checked after every clock edge.
module tb_cordic_result_fifo;

    localparam int DW = 16;
    localparam int CH = 3;
    localparam int DEPTH = 32;
    localparam int LW = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [CH*DW-1:0] in_dat_i = '0;
    logic            in_vld_i = 1'b0;
    logic            in_rdy_o;
    logic            afull_o;
    logic [CH*DW-1:0] out_dat_o;
    logic            out_vld_o;
    logic            out_rdy_i = 1'b0;
    logic [LW-1:0]   level_o;
    logic            overflow_o;
    logic            flush_i = 1'b0;

    cordic_result_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .in_dat_i  (in_dat_i),
        .in_vld_i  (in_vld_i),
        .in_rdy_o  (in_rdy_o),
        .afull_o   (afull_o),
        .out_dat_o (out_dat_o),
        .out_vld_o (out_vld_o),
        .out_rdy_i (out_rdy_i),
        .level_o   (level_o),
        .overflow_o(overflow_o),
        .flush_i   (flush_i)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    logic [CH*DW-1:0] sb[$];
    int   m_level = 0;
    logic m_rdy = 1'b0;
    logic m_ovf = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("level", 64'(level_o), 64'(m_level));
        chk("out_vld", 64'(out_vld_o), 64'(m_level != 0));
        chk("in_rdy", 64'(in_rdy_o), 64'(m_rdy));
        chk("afull", 64'(afull_o), 64'(m_level >= 16));
        chk("overflow", 64'(overflow_o), 64'(m_ovf));
        if (sb.size() > 0) chk("head", 64'(out_dat_o), 64'(sb[0]));
        else               chk("head_mask", 64'(out_dat_o), 64'(0));
    endtask

    task automatic cyc(input logic v, input logic [CH*DW-1:0] d,
                       input logic r, input logic f);
        logic wr, rd;
        in_vld_i  = v;
        in_dat_i  = d;
        out_rdy_i = r;
        flush_i   = f;
        rd = r && (m_level > 0) && !f;
        wr = v && m_rdy && !f;
        if (rd) chk("rd_data", 64'(out_dat_o), 64'(sb.pop_front()));
        if (wr) sb.push_back(d);
        @(posedge clk);
        #1;
        if (f) begin
            m_level = 0;
            m_ovf = 1'b0;
            sb.delete();
        end else begin
            if (v && !m_rdy) m_ovf = 1'b1;
            m_level = m_level + (wr ? 1 : 0) - (rd ? 1 : 0);
        end
        m_rdy = (m_level != DEPTH);
        check_state();
    endtask

    initial begin
        logic v, r;
        int nw, seq, guard;

        #2;
        check_state();
        @(negedge clk);
        rst = 1'b1;
        cyc(0, '0, 0, 0);

        // single word
        cyc(1, 48'h0003_0002_0001, 0, 0);
        chk("single_dat", 64'(out_dat_o), 64'h0003_0002_0001);
        cyc(0, '0, 1, 0);
        chk("single_empty", 64'(out_dat_o), 64'(0));

        // fill to full and overflow
        for (int i = 0; i <= DEPTH; i++) begin
            cyc(1, 48'(i), 0, 0);
            if (i == 15) chk("afull_at16", 64'(afull_o), 64'(1));
            if (i == 14) chk("afull_at15", 64'(afull_o), 64'(0));
        end
        chk("full_level", 64'(level_o), 64'(32));
        chk("full_rdy", 64'(in_rdy_o), 64'(0));
        chk("ovf_set", 64'(overflow_o), 64'(1));

        // full with concurrent read: write dropped
        cyc(1, 48'h0BAD, 1, 0);
        chk("full_rw_level", 64'(level_o), 64'(31));
        while (m_level > 0) cyc(0, '0, 1, 0);

        // flush at level 10 with overflow set
        for (int i = 0; i < 10; i++) cyc(1, 48'(100 + i), 0, 0);
        chk("pre_flush_ovf", 64'(overflow_o), 64'(1));
        cyc(1, 48'hDEAD_DEAD_DEAD, 0, 1);
        chk("flush_rdy", 64'(in_rdy_o), 64'(1));
        chk("flush_level", 64'(level_o), 64'(0));
        cyc(0, '0, 1, 0);

        // asynchronous reset mid-stream at level 7
        for (int i = 0; i < 7; i++) cyc(1, 48'(200 + i), 0, 0);
        #2;
        rst = 1'b0;
        #1;
        sb.delete();
        m_level = 0;
        m_ovf = 1'b0;
        m_rdy = 1'b0;
        check_state();
        @(negedge clk);
        rst = 1'b1;
        cyc(0, '0, 0, 0);

        // streaming with wrap
        seq = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1, {16'(seq + 2), 16'(seq + 1), 16'(seq)}, 0, 0);
            seq++;
        end
        nw = 0;
        guard = 0;
        while (nw < 200 && guard < 5000) begin
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            if (m_level >= 30) v = 1'b0;
            if (v && m_rdy) begin
                nw++;
                cyc(1, {16'(seq + 2), 16'(seq + 1), 16'(seq)}, r, 0);
                seq++;
            end else begin
                cyc(0, '0, r, 0);
            end
            guard++;
        end
        chk("stream_done", 64'(nw), 64'(200));
        while (m_level > 0) cyc(0, '0, 1, 0);
        chk("stream_ovf", 64'(overflow_o), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
